// File: rtl/sha_pkg.sv
// Shared definitions for the nonce-sweep hasher result path: bus widths,
// scan FSM states and the summary-word layout used by readback software.
package sha_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 32;

  // Summary word layout: found | zero | win_nonce | hit_count
  localparam int SUM_FOUND_BIT = 31;
  localparam int SUM_WIN_LSB   = 16;
  localparam int SUM_WIN_W     = 8;
  localparam int SUM_HIT_LSB   = 0;
  localparam int SUM_HIT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIN   = 3'd3
`ifdef SCAN_WRITEBACK_EN
    , ST_WB  = 3'd4
`endif
  } scan_state_t;

  function automatic logic [MEM_DATA_W-1:0] pack_summary(
    input logic                 found,
    input logic [SUM_WIN_W-1:0] win,
    input logic [SUM_HIT_W-1:0] hits
  );
    logic [MEM_DATA_W-1:0] s;
    s = '0;
    s[SUM_FOUND_BIT]                     = found;
    s[SUM_WIN_LSB +: SUM_WIN_W]          = win;
    s[SUM_HIT_LSB +: SUM_HIT_W]          = hits;
    return s;
  endfunction

endpackage

// File: rtl/nonce_cmp_acc.sv
// Comparison accumulator: tracks first winning nonce, saturating hit count
// and the minimum hash (lowest nonce wins ties) over one scan.
module nonce_cmp_acc
  import sha_pkg::*;
#(
  parameter int NONCE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  valid,
  input  logic [MEM_DATA_W-1:0] word,
  input  logic [NONCE_W-1:0]    index,
  input  logic [MEM_DATA_W-1:0] target,
  output logic                  found,
  output logic [NONCE_W-1:0]    win_nonce,
  output logic [NONCE_W-1:0]    hit_count,
  output logic [MEM_DATA_W-1:0] best_hash,
  output logic [NONCE_W-1:0]    best_nonce
);

  logic hit;
  logic better;

  assign hit    = (word < target);
  // Word 0 always seeds the minimum, even if it is all ones.
  assign better = (word < best_hash) || (index == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      found      <= 1'b0;
      win_nonce  <= '0;
      hit_count  <= '0;
      best_hash  <= '1;
      best_nonce <= '0;
    end else if (clear) begin
      found      <= 1'b0;
      win_nonce  <= '0;
      hit_count  <= '0;
      best_hash  <= '1;
      best_nonce <= '0;
    end else if (valid) begin
      if (hit) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
        if (!found) begin
          found     <= 1'b1;
          win_nonce <= index;
        end
      end
      if (better) begin
        best_hash  <= word;
        best_nonce <= index;
      end
    end
  end

endmodule

// File: rtl/nonce_result_scan.sv
// Reads back NUM_NONCES hasher result words and reports winners/minimum.
// Optional summary writeback after the scan when SCAN_WRITEBACK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; results held
// SCAN  | issuing read addresses, one per cycle
// DRAIN | address issue done, waiting for final captures
// WB    | writing the summary word (SCAN_WRITEBACK_EN only)
// FIN   | one-cycle done pulse
module nonce_result_scan
  import sha_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int NONCE_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [MEM_ADDR_W-1:0] result_addr,
  input  logic [MEM_DATA_W-1:0] target,
  output logic                  done,
  output logic                  found,
  output logic [NONCE_W-1:0]    win_nonce,
  output logic [NONCE_W-1:0]    hit_count,
  output logic [MEM_DATA_W-1:0] best_hash,
  output logic [NONCE_W-1:0]    best_nonce,
  output logic                  mem_clk,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_write_data,
  input  logic [MEM_DATA_W-1:0] mem_read_data
);

  localparam logic [NONCE_W-1:0] LAST_IDX = NONCE_W'(NUM_NONCES - 1);

  scan_state_t           state;
  logic [MEM_DATA_W-1:0] target_q;
  logic [NONCE_W-1:0]    iss_cnt;
  logic [NONCE_W-1:0]    cap_cnt;
  logic                  addr_vld;
  logic                  data_vld;
  logic                  acc_clear;

  assign mem_clk   = clk;
  assign acc_clear = (state == ST_IDLE) && start;

`ifdef SCAN_WRITEBACK_EN
  logic wb_issued;
`else
  assign mem_we         = 1'b0;
  assign mem_write_data = '0;
`endif

  // addr_vld: mem_addr holds a live read address; data_vld: read data lands next edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      target_q       <= '0;
      mem_addr       <= '0;
      iss_cnt        <= '0;
      cap_cnt        <= '0;
      addr_vld       <= 1'b0;
      data_vld       <= 1'b0;
      done           <= 1'b0;
`ifdef SCAN_WRITEBACK_EN
      mem_we         <= 1'b0;
      mem_write_data <= '0;
      wb_issued      <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      data_vld <= addr_vld;
      if (data_vld) cap_cnt <= cap_cnt + 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            target_q <= target;
            mem_addr <= result_addr;
            iss_cnt  <= '0;
            cap_cnt  <= '0;
            addr_vld <= 1'b1;
            state    <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (iss_cnt == LAST_IDX) begin
            addr_vld <= 1'b0;
            state    <= ST_DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
            iss_cnt  <= iss_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (data_vld && (cap_cnt == LAST_IDX)) begin
`ifdef SCAN_WRITEBACK_EN
            state <= ST_WB;
`else
            state <= ST_FIN;
`endif
          end
        end
`ifdef SCAN_WRITEBACK_EN
        ST_WB: begin
          if (!wb_issued) begin
            // mem_addr still holds the last result word; summary goes just past it.
            mem_addr       <= mem_addr + 1'b1;
            mem_we         <= 1'b1;
            mem_write_data <= pack_summary(found, SUM_WIN_W'(win_nonce),
                                           SUM_HIT_W'(hit_count));
            wb_issued      <= 1'b1;
          end else begin
            mem_we    <= 1'b0;
            wb_issued <= 1'b0;
            state     <= ST_FIN;
          end
        end
`endif
        ST_FIN: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  nonce_cmp_acc #(
    .NONCE_W (NONCE_W)
  ) u_acc (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (acc_clear),
    .valid      (data_vld),
    .word       (mem_read_data),
    .index      (cap_cnt),
    .target     (target_q),
    .found      (found),
    .win_nonce  (win_nonce),
    .hit_count  (hit_count),
    .best_hash  (best_hash),
    .best_nonce (best_nonce)
  );

endmodule

// File: tb/tb_nonce_result_scan.sv
// Self-checking bench for nonce_result_scan: vector table + scoreboard queue,
// plus hand-written reset-mid-scan and start re-pulse sequences.
module tb_nonce_result_scan;

  localparam int NUM = 16;
  localparam int NW  = 8;
  localparam int NV  = 6;
`ifdef SCAN_WRITEBACK_EN
  localparam int LAT   = NUM + 4;
  localparam int NADDR = NUM + 1;
`else
  localparam int LAT   = NUM + 2;
  localparam int NADDR = NUM;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [15:0]   result_addr;
  logic [31:0]   target;
  logic          done;
  logic          found;
  logic [NW-1:0] win_nonce;
  logic [NW-1:0] hit_count;
  logic [31:0]   best_hash;
  logic [NW-1:0] best_nonce;
  logic          mem_clk;
  logic          mem_we;
  logic [15:0]   mem_addr;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  always #5 clk = ~clk;

  nonce_result_scan #(.NUM_NONCES(NUM), .NONCE_W(NW)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .result_addr    (result_addr),
    .target         (target),
    .done           (done),
    .found          (found),
    .win_nonce      (win_nonce),
    .hit_count      (hit_count),
    .best_hash      (best_hash),
    .best_nonce     (best_nonce),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Single-port memory with one-cycle registered read.
  logic [31:0] img [256];
  logic [31:0] rdata_q;
  assign mem_read_data = rdata_q;
  always @(posedge clk) rdata_q <= img[mem_addr[7:0]];

  typedef struct packed {
    logic [15:0]   base;
    logic [31:0]   tgt;
    logic          ef;
    logic [NW-1:0] ew;
    logic [NW-1:0] eh;
    logic [31:0]   eb;
    logic [NW-1:0] en;
  } vec_t;

  vec_t        vt [NV];
  logic [31:0] vw [NV][NUM];
  vec_t        sb [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: distinct address sequence and write activity.
  logic [15:0] addr_q [$];
  logic [15:0] last_addr;
  bit          mon_first = 1'b0;
  int          we_cycles = 0;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_first || mem_addr != last_addr) begin
        addr_q.push_back(mem_addr);
        last_addr = mem_addr;
        mon_first = 1'b0;
      end
      if (mem_we) begin
        we_cycles++;
        wr_addr = mem_addr;
        wr_data = mem_write_data;
      end
    end
  end

  task automatic load_words(input int idx);
    for (int i = 0; i < NUM; i++) img[(int'(vt[idx].base) + i) & 255] = vw[idx][i];
    img[(int'(vt[idx].base) + NUM) & 255] = 32'h0;
  endtask

  task automatic run_vector(input int idx, input bit repulse);
    vec_t e;
    int   cyc;
    bit   got;
    int   extra;
    load_words(idx);
    sb.push_back(vt[idx]);
    @(negedge clk);
    result_addr = vt[idx].base;
    target      = vt[idx].tgt;
    addr_q.delete();
    mon_first   = 1'b1;
    we_cycles   = 0;
    start       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start       = 1'b0;
    target      = 32'h0;
    result_addr = 16'hBEEF;
    cyc = 0;
    got = 1'b0;
    while (cyc < 60 && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) got = 1'b1;
      else if (repulse && cyc == 5) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 32'd1);
    chk("done_latency", 32'(cyc), 32'(LAT));
    e = sb.pop_front();
    chk("found", 32'(found), 32'(e.ef));
    chk("win_nonce", 32'(win_nonce), 32'(e.ew));
    chk("hit_count", 32'(hit_count), 32'(e.eh));
    chk("best_hash", best_hash, e.eb);
    chk("best_nonce", 32'(best_nonce), 32'(e.en));
    chk("addr_count", 32'(addr_q.size()), 32'(NADDR));
    for (int i = 0; i < NADDR && i < addr_q.size(); i++)
      chk("addr_seq", 32'(addr_q[i]), 32'(e.base + 16'(i)));
`ifdef SCAN_WRITEBACK_EN
    chk("we_cycles", 32'(we_cycles), 32'd1);
    chk("wb_addr", 32'(wr_addr), 32'(e.base + 16'(NUM)));
    chk("wb_data", wr_data, {e.ef, 7'b0, e.ew, 8'h00, e.eh});
`else
    chk("we_cycles", 32'(we_cycles), 32'd0);
`endif
    @(posedge clk);
    #1;
    chk("done_width", 32'(done), 32'd0);
    chk("hold_hits", 32'(hit_count), 32'(e.eh));
    if (repulse) begin
      extra = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk);
        #1;
        if (done) extra++;
      end
      chk("extra_done", 32'(extra), 32'd0);
    end
  endtask

  initial begin
    int dcount;
    // base, target, found, win, hits, best_hash, best_nonce
    vt[0] = '{16'h0000, 32'h0001_0000, 1'b0, 8'd0, 8'd0,  32'h8000_0000, 8'd0};
    vt[1] = '{16'h0040, 32'h0001_0000, 1'b1, 8'd5, 8'd1,  32'h0000_1234, 8'd5};
    vt[2] = '{16'h0020, 32'h0001_0000, 1'b1, 8'd3, 8'd3,  32'h0000_0100, 8'd9};
    vt[3] = '{16'h0060, 32'h0000_0001, 1'b1, 8'd0, 8'd16, 32'h0000_0000, 8'd0};
    vt[4] = '{16'h0080, 32'h0000_0000, 1'b0, 8'd0, 8'd0,  32'hFFFF_FFFF, 8'd0};
    vt[5] = '{16'h00A0, 32'h0000_0FC0, 1'b1, 8'd5, 8'd11, 32'h0000_0F10, 8'd15};
    for (int i = 0; i < NUM; i++) begin
      vw[0][i] = 32'h8000_0000;
      vw[1][i] = 32'hFFFF_FFFF;
      vw[2][i] = 32'hFFFF_FFFF;
      vw[3][i] = 32'h0;
      vw[4][i] = 32'hFFFF_FFFF;
      vw[5][i] = 32'h0000_1000 - 32'(i * 16);
    end
    vw[1][5]  = 32'h0000_1234;
    vw[2][3]  = 32'h0000_F000;
    vw[2][7]  = 32'h0001_0000;
    vw[2][9]  = 32'h0000_0100;
    vw[2][12] = 32'h0000_0100;
    for (int i = 0; i < 256; i++) img[i] = 32'h0;

    reset_n     = 1'b0;
    start       = 1'b0;
    result_addr = 16'h0;
    target      = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_hits", 32'(hit_count), 32'd0);
    chk("rst_win", 32'(win_nonce), 32'd0);
    chk("rst_best", best_hash, 32'hFFFF_FFFF);
    chk("rst_bnonce", 32'(best_nonce), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < NV; v++) run_vector(v, 1'b0);

    // Reset six cycles into a scan of all-hit data, then a fresh run.
    load_words(3);
    @(negedge clk);
    result_addr = vt[3].base;
    target      = vt[3].tgt;
    start       = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_done", 32'(dcount), 32'd0);
    chk("mid_rst_hits", 32'(hit_count), 32'd0);
    chk("mid_rst_found", 32'(found), 32'd0);
    chk("mid_rst_best", best_hash, 32'hFFFF_FFFF);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vector(1, 1'b0);

    // Start re-pulsed mid-scan must be ignored.
    run_vector(2, 1'b1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
